// File: rtl/calc_pkg.sv
// Shared constants, opcodes and FSM encoding for the calculator ALU stage.
package calc_pkg;

  localparam int unsigned NR_W  = 4;
  localparam int unsigned RES_W = 8;

  localparam logic [NR_W-1:0] OP_ADD = 4'b0001;
  localparam logic [NR_W-1:0] OP_SUB = 4'b0010;
  localparam logic [NR_W-1:0] OP_MUL = 4'b0011;
  localparam logic [NR_W-1:0] OP_DIV = 4'b0100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ITER,
    ST_FIX,
    ST_DONE
  } state_t;

endpackage

// File: rtl/calc_seq_muldiv.sv
// Unsigned 4-iteration shift-add multiplier / restoring divider.
// Divide datapath present only when CALC_ALU_DIV_EN is defined.
module calc_seq_muldiv
  import calc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             mode,
  input  logic [NR_W-1:0]  a_mag,
  input  logic [NR_W-1:0]  b_mag,
`ifdef CALC_ALU_DIV_EN
  output logic [NR_W-1:0]  quotient,
  output logic [NR_W-1:0]  remainder,
`endif
  output logic [RES_W-1:0] product
);

  logic [RES_W-1:0] acc_q, acc_d, mcand_q, mcand_d;
  logic [NR_W-1:0]  mplier_q, mplier_d;

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (load) begin
      acc_d    = '0;
      mcand_d  = {{(RES_W-NR_W){1'b0}}, a_mag};
      mplier_d = b_mag;
    end else if (step && !mode) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

  assign product = acc_q;

`ifdef CALC_ALU_DIV_EN
  logic [NR_W-1:0] pr_q, pr_d, q_q, q_d, dv_q, dv_d;
  logic [NR_W:0]   sh;

  // Partial remainder stays below the divisor (<=8), so after the subtract
  // the low 4 bits of the shifted value are exact.
  always_comb begin
    pr_d = pr_q;
    q_d  = q_q;
    dv_d = dv_q;
    sh   = {pr_q, q_q[NR_W-1]};
    if (load) begin
      pr_d = '0;
      q_d  = a_mag;
      dv_d = b_mag;
    end else if (step && mode) begin
      if (sh >= {1'b0, dv_q}) begin
        pr_d = sh[NR_W-1:0] - dv_q;
        q_d  = {q_q[NR_W-2:0], 1'b1};
      end else begin
        pr_d = sh[NR_W-1:0];
        q_d  = {q_q[NR_W-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pr_q <= '0;
      q_q  <= '0;
      dv_q <= '0;
    end else begin
      pr_q <= pr_d;
      q_q  <= q_d;
      dv_q <= dv_d;
    end
  end

  assign quotient  = q_q;
  assign remainder = pr_q;
`endif

endmodule

// File: rtl/calc_alu.sv
// Sequential signed ADD/SUB/MUL/DIV stage with edge-triggered start.
// DIV support is enabled by defining CALC_ALU_DIV_EN.
module calc_alu
  import calc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [NR_W-1:0]  first_nr,
  input  logic [NR_W-1:0]  second_nr,
  input  logic [NR_W-1:0]  operation,
  input  logic             complement1_finish,
  output logic [RES_W-1:0] result,
  output logic [NR_W-1:0]  remainder,
  output logic             alu_error,
  output logic             alu_busy,
  output logic             alu_done
);

  state_t           state_q, state_d;
  logic             fin_q, start;
  logic [1:0]       cnt_q, cnt_d;
  logic [NR_W-1:0]  a_q, a_d, b_q, b_d, op_q, op_d;
  logic [RES_W-1:0] result_q, result_d;
  logic             err_q, err_d;
  logic             md_load, md_step, md_mode, neg;
  logic [NR_W-1:0]  a_mag, b_mag;
  logic [RES_W-1:0] a_ext, b_ext, product;

  assign start   = complement1_finish & ~fin_q;
  assign a_mag   = a_q[NR_W-1] ? (~a_q + 1'b1) : a_q;
  assign b_mag   = b_q[NR_W-1] ? (~b_q + 1'b1) : b_q;
  assign a_ext   = {{(RES_W-NR_W){a_q[NR_W-1]}}, a_q};
  assign b_ext   = {{(RES_W-NR_W){b_q[NR_W-1]}}, b_q};
  assign neg     = a_q[NR_W-1] ^ b_q[NR_W-1];
  assign md_mode = (op_q == OP_DIV);

`ifdef CALC_ALU_DIV_EN
  logic [NR_W-1:0] rem_q, rem_d, md_quot, md_rem;
`endif

  calc_seq_muldiv u_muldiv (
    .clk       (clk),
    .rst       (rst),
    .load      (md_load),
    .step      (md_step),
    .mode      (md_mode),
    .a_mag     (a_mag),
    .b_mag     (b_mag),
`ifdef CALC_ALU_DIV_EN
    .quotient  (md_quot),
    .remainder (md_rem),
`endif
    .product   (product)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    err_d    = err_q;
    md_load  = 1'b0;
    md_step  = 1'b0;
`ifdef CALC_ALU_DIV_EN
    rem_d    = rem_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = first_nr;
          b_d     = second_nr;
          op_d    = operation;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        state_d = ST_DONE;
        case (op_q)
          OP_ADD: begin
            result_d = a_ext + b_ext;
            err_d    = 1'b0;
`ifdef CALC_ALU_DIV_EN
            rem_d    = '0;
`endif
          end
          OP_SUB: begin
            result_d = a_ext - b_ext;
            err_d    = 1'b0;
`ifdef CALC_ALU_DIV_EN
            rem_d    = '0;
`endif
          end
          OP_MUL: begin
            md_load = 1'b1;
            cnt_d   = '0;
            state_d = ST_ITER;
          end
`ifdef CALC_ALU_DIV_EN
          OP_DIV: begin
            if (b_q != '0) begin
              md_load = 1'b1;
              cnt_d   = '0;
              state_d = ST_ITER;
            end else begin
              result_d = '0;
              rem_d    = '0;
              err_d    = 1'b1;
            end
          end
`endif
          default: begin
            result_d = '0;
            err_d    = 1'b1;
`ifdef CALC_ALU_DIV_EN
            rem_d    = '0;
`endif
          end
        endcase
      end
      ST_ITER: begin
        md_step = 1'b1;
        cnt_d   = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = ST_FIX;
      end
      ST_FIX: begin
        err_d   = 1'b0;
        state_d = ST_DONE;
`ifdef CALC_ALU_DIV_EN
        if (op_q == OP_DIV) begin
          result_d = neg ? -{{(RES_W-NR_W){1'b0}}, md_quot}
                         :  {{(RES_W-NR_W){1'b0}}, md_quot};
          rem_d    = a_q[NR_W-1] ? -md_rem : md_rem;
        end else begin
          result_d = neg ? -product : product;
          rem_d    = '0;
        end
`else
        result_d = neg ? -product : product;
`endif
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      fin_q    <= 1'b0;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      fin_q    <= complement1_finish;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

`ifdef CALC_ALU_DIV_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rem_q <= '0;
    else      rem_q <= rem_d;
  end
  assign remainder = rem_q;
`else
  assign remainder = '0;
`endif

  assign result    = result_q;
  assign alu_error = err_q;
  assign alu_busy  = (state_q != ST_IDLE);
  assign alu_done  = (state_q == ST_DONE);

endmodule

// File: doc/calc_alu.md
# calc_alu

Sequential signed arithmetic stage of the calculator datapath, directly downstream of `complement_to_2`. It consumes the decoded 4-bit two's-complement operands and the operation code, starting on the rising edge of `complement1_finish`. ADD and SUB complete in one execute cycle; MUL (shift-add) and DIV (restoring) iterate over 4 cycles. It produces an 8-bit signed result, a 4-bit remainder, an error flag and a one-cycle done pulse for the display/output stage.

## Interface
- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  reset; asynchronous, active-low (0 = reset)
- `first_nr`  in  4  operand A, two's complement, −8..7
- `second_nr`  in  4  operand B, two's complement, −8..7
- `operation`  in  4  opcode: 0001 ADD, 0010 SUB, 0011 MUL, 0100 DIV; all other codes are invalid
- `complement1_finish`  in  1  operands-valid level from upstream; its rising edge is the start
- `result`  out  8  signed result, sign-extended
- `remainder`  out  4  signed DIV remainder; 0 for other operations
- `alu_error`  out  1  invalid opcode or divide by zero
- `alu_busy`  out  1  high in every state except IDLE
- `alu_done`  out  1  one-cycle pulse when `result`, `remainder` and `alu_error` are updated

## Operation
- Start detection: register `fin_q` holds the previous `complement1_finish`. `start = complement1_finish & ~fin_q`. `fin_q` updates every cycle, including while busy.
- FSM states: IDLE, LOAD, ITER, FIX, DONE.
  - IDLE→LOAD when `start`. Operands and opcode are latched here.
  - LOAD, ADD/SUB: compute the 8-bit sign-extended A+B or A−B, write outputs, go to DONE.
  - LOAD, MUL/DIV: take magnitudes and compute sign = A[3]^B[3], clear counter, go to ITER.
  - LOAD, invalid opcode or DIV with B=0: `result`=0, `remainder`=0, `alu_error`=1, go to DONE.
  - ITER: 4 iterations, 2-bit counter 0..3. On the counter=3 edge, go to FIX.
    - MUL: shift-add over the 4 multiplier bits.
    - DIV: restoring, one quotient bit per iteration.
  - FIX: apply the sign to the product or quotient. The remainder sign follows the dividend. Write outputs with `alu_error`=0, go to DONE.
  - DONE: `alu_done`=1 for this cycle only, then go to IDLE.
- Arithmetic rules:
  - No overflow is possible at 8 bits: −8×−8=64 and −8/−1=8.
  - DIV truncates toward zero.
  - Magnitudes are 4 bits unsigned, so |−8|=8 is representable.
- `result`, `remainder` and `alu_error` hold their values until the next DONE.
- A `start` seen while not in IDLE is ignored, not queued. A level held high produces exactly one operation.

## Timing
- Edge 0 is the first edge sampling `complement1_finish`=1 with `fin_q`=0; the FSM enters LOAD.
- ADD/SUB and error cases: outputs update and `alu_done` goes high after edge 1, for one cycle. Idle again after edge 2.
- MUL/DIV: ITER after edge 1, iterations at edges 2–5, FIX after edge 5. Outputs update and `alu_done` goes high after edge 6.
- Reset (`rst`=0), asynchronous:
  - `result`=0, `remainder`=0, `alu_error`=0, `alu_busy`=0, `alu_done`=0, `fin_q`=0, state IDLE, counter 0.
  - Reset mid-operation aborts the operation with no done pulse.
- If `complement1_finish` is already high when reset releases, it counts as a start at the first edge.

## Configuration
- `CALC_ALU_DIV_EN` defined: DIV (0100) is implemented as above.
- Not defined:
  - The DIV datapath is removed.
  - Opcode 0100 is treated as invalid: error path, `alu_done` after edge 1.
  - `remainder` is tied to 0.

## Structure
- Shared package `calc_pkg`:
  - opcode constants OP_ADD, OP_SUB, OP_MUL, OP_DIV
  - FSM state encoding
  - widths NR_W=4 and RES_W=8
- Sub-module `calc_seq_muldiv`: the unsigned 4-iteration shift-add / restoring-divide datapath. Inputs: load, step, mode. Outputs: 8-bit product, 4-bit quotient, 4-bit remainder.
- The FSM, start detection, sign handling and output registers stay in `calc_alu`.

## Test plan
- ADD 3+(−5) (A=0011, B=1011, op 0001) → `result`=8'hFE, `alu_error`=0, `alu_done` after edge 1. SUB −8−7 → 8'hF1.
- MUL 7×(−3) → 8'hEB; MUL −8×−8 → 8'h40. `alu_done` after edge 6 with `alu_busy` high from edge 0 through DONE.
- DIV −8/3 → `result`=8'hFE, `remainder`=4'hE. DIV 5/0 → `alu_error`=1, `result`=0, `alu_done` after edge 1.
- Opcode 1111 → `alu_error`=1. `complement1_finish` held high 20 cycles → exactly one `alu_done`. A second rising edge during MUL ITER → ignored.
- `rst`=0 during the second MUL iteration → all outputs 0 immediately, no done pulse. The next start → correct result.
- Build without `CALC_ALU_DIV_EN`: DIV 6/2 → `alu_error`=1, `result`=0, `remainder`=0.
